// File: rtl/stream_downsize_if.sv
// Handshake bundle for stream_downsize: wide input beat and narrow output beat.
interface stream_downsize_if #(
    parameter int T_DATA_WIDTH = 1,
    parameter int T_DATA_RATIO = 2
);
    logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] s_keep_i;
    logic                    s_last_i;
    logic                    s_valid_i;
    logic                    s_ready_o;
    logic [T_DATA_WIDTH-1:0] m_data_o;
    logic                    m_last_o;
    logic                    m_valid_o;
    logic                    m_ready_i;

    modport slave (
        input  s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_last_o, m_valid_o
    );

    modport master (
        output s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_last_o, m_valid_o
    );
endinterface

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter, lowest kept lane first.
// Lane skipping via s_keep_i only when STREAM_DOWNSIZE_KEEP_EN is defined.
module stream_downsize #(
    parameter int T_DATA_WIDTH = 1,
    parameter int T_DATA_RATIO = 2
) (
    input logic              clk,
    input logic              rst,
    stream_downsize_if.slave bus
);
    localparam int IW = $clog2(T_DATA_RATIO);
    localparam logic [T_DATA_RATIO-1:0] LSB =
        {{(T_DATA_RATIO-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [T_DATA_WIDTH-1:0] buf_data [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] buf_rem;
    logic [T_DATA_RATIO-1:0] rem_nxt;
    logic [T_DATA_RATIO-1:0] load_rem;
    logic                    buf_last;
    logic [IW-1:0]           k;
    logic                    one_left;
    logic                    accept;
    logic                    pop;

`ifdef STREAM_DOWNSIZE_KEEP_EN
    assign load_rem = bus.s_keep_i;
`else
    logic unused_keep;
    assign unused_keep = ^bus.s_keep_i;
    assign load_rem    = '1;
`endif

    always_comb begin
        k = '0;
        for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
            if (buf_rem[i]) k = IW'(i);
        end
    end

    assign one_left = (buf_rem != '0) &&
                      ((buf_rem & (buf_rem - LSB)) == '0);

    always_comb begin
        bus.m_valid_o = (state == SEND);
        bus.m_data_o  = buf_data[k];
        bus.m_last_o  = one_left && buf_last;
        pop           = bus.m_valid_o && bus.m_ready_i;
        // popping the final lane frees the buffer in the same cycle
        bus.s_ready_o = !rst && ((state == IDLE) || (pop && one_left));
        accept        = bus.s_valid_i && bus.s_ready_o;
        rem_nxt       = buf_rem;
        if (pop) rem_nxt = buf_rem & ~(LSB << k);
        if (accept) rem_nxt = load_rem;
        state_nxt = (rem_nxt != '0) ? SEND : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            buf_rem  <= '0;
            buf_last <= 1'b0;
            for (int i = 0; i < T_DATA_RATIO; i++) begin
                buf_data[i] <= '0;
            end
        end else begin
            state   <= state_nxt;
            buf_rem <= rem_nxt;
            if (accept) begin
                buf_last <= bus.s_last_i;
                for (int i = 0; i < T_DATA_RATIO; i++) begin
                    buf_data[i] <= bus.s_data_i[i];
                end
            end
        end
    end
endmodule
